load_unit_rd: RTL and testbench

Load-side counterpart to the store path in the LSU: accepts one load from the LSU issue stage and obtains its address translation from the MMU. It issues a two-phase read (index, then tag) on a D$ read port and returns the aligned, sign- or zero-extended result to writeback. The store path writes through the store buffer; this block reads through the D$. It consults the store buffer's page-offset checker so that a load never bypasses an uncommitted store to the same offset.

---
 rtl/load_unit_rd.sv | 233 +++++++++++++++++++++++
 tb/tb_load_unit_rd.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit_rd.sv
// Load unit read path: one outstanding load, two-phase D$ read (index, then tag), aligned and extended result.
// Optional LOAD_UNIT_PAGE_OFFSET_CHECK_EN: stall on store-buffer page-offset match instead of on a non-empty store buffer.
module load_unit_rd #(
    parameter int XLEN          = 64,
    parameter int VLEN          = 39,
    parameter int PLEN          = 56,
    parameter int TRANS_ID_BITS = 3,
    localparam int BE_W         = XLEN / 8,
    localparam int CTRL_W       = VLEN + BE_W + 3 + TRANS_ID_BITS,
    localparam int EX_W         = 2 * XLEN + 1,
    localparam int DREQ_O_W     = XLEN + 2,
    localparam int DREQ_I_W     = PLEN + 14
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    // lsu_ctrl_i = {vaddr, be, operator[2:0], trans_id}
    input  logic [CTRL_W-1:0]        lsu_ctrl_i,
    output logic                     pop_ld_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN-1:0]          result_o,
    // exception = {tval, cause, valid}
    output logic [EX_W-1:0]          ex_o,
    output logic                     translation_req_o,
    output logic [VLEN-1:0]          vaddr_o,
    input  logic [PLEN-1:0]          paddr_i,
    input  logic [EX_W-1:0]          ex_i,
    input  logic                     dtlb_hit_i,
    output logic [11:0]              page_offset_o,
    input  logic                     page_offset_matches_i,
    input  logic                     store_buffer_empty_i,
    // req_port_i = {data_gnt, data_rvalid, data_rdata}
    input  logic [DREQ_O_W-1:0]      req_port_i,
    // req_port_o = {address_index, address_tag, data_be, data_size, data_req, data_we, kill_req, tag_valid}
    output logic [DREQ_I_W-1:0]      req_port_o,
    output logic [2:0]               fsm_state
);

    // Operator encoding; the low two bits double as the D$ access size.
    localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LD = 3'd3,
                           OP_LBU = 3'd4, OP_LHU = 3'd5, OP_LWU = 3'd6;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        WAIT_PAGE_OFFSET = 3'd1,
        WAIT_GNT         = 3'd2,
        SEND_TAG         = 3'd3,
        WAIT_TRANSLATION = 3'd4,
        WAIT_RVALID      = 3'd5,
        WAIT_FLUSH       = 3'd6
    } state_t;

    state_t state, next_state;

    logic [TRANS_ID_BITS-1:0] ctrl_id;
    logic [2:0]               ctrl_op;
    logic [BE_W-1:0]          ctrl_be;
    logic [VLEN-1:0]          ctrl_vaddr;
    logic                     data_gnt, data_rvalid;
    logic [XLEN-1:0]          data_rdata;
    logic                     hazard;

    assign ctrl_id     = lsu_ctrl_i[TRANS_ID_BITS-1:0];
    assign ctrl_op     = lsu_ctrl_i[TRANS_ID_BITS +: 3];
    assign ctrl_be     = lsu_ctrl_i[TRANS_ID_BITS+3 +: BE_W];
    assign ctrl_vaddr  = lsu_ctrl_i[CTRL_W-1 -: VLEN];
    assign data_rdata  = req_port_i[XLEN-1:0];
    assign data_rvalid = req_port_i[XLEN];
    assign data_gnt    = req_port_i[XLEN+1];
    assign vaddr_o     = ctrl_vaddr;
    assign fsm_state   = state;

`ifdef LOAD_UNIT_PAGE_OFFSET_CHECK_EN
    logic unused_bits;
    assign unused_bits   = ^{paddr_i[11:0], store_buffer_empty_i};
    assign hazard        = page_offset_matches_i;
    assign page_offset_o = ctrl_vaddr[11:0];
`else
    logic unused_bits;
    assign unused_bits   = ^{paddr_i[11:0], page_offset_matches_i};
    assign hazard        = !store_buffer_empty_i;
    assign page_offset_o = 12'd0;
`endif

    logic              data_req, tag_valid, kill_req, do_issue;
    logic [11:0]       address_index;
    logic [PLEN-13:0]  address_tag;
    logic [BE_W-1:0]   data_be;
    logic [1:0]        data_size;
    logic              capture_data, capture_ex, latch_ld;

    assign req_port_o = {address_index, address_tag, data_be, data_size,
                         data_req, 1'b0, kill_req, tag_valid};

    // Handshake: valid_i holds lsu_ctrl_i until pop_ld_o; the D$ accepts the
    // index phase on data_req & data_gnt and returns data on data_rvalid.
    always_comb begin
        next_state        = state;
        pop_ld_o          = 1'b0;
        translation_req_o = 1'b0;
        data_req          = 1'b0;
        tag_valid         = 1'b0;
        kill_req          = 1'b0;
        address_index     = '0;
        address_tag       = '0;
        data_be           = '0;
        data_size         = '0;
        capture_data      = 1'b0;
        capture_ex        = 1'b0;
        latch_ld          = 1'b0;
        do_issue          = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        if (hazard) next_state = WAIT_PAGE_OFFSET;
                        else        do_issue   = 1'b1;
                    end
                end
                WAIT_PAGE_OFFSET: begin
                    if (flush_i)      next_state = IDLE;
                    else if (!hazard) do_issue   = 1'b1;
                end
                WAIT_GNT: begin
                    if (flush_i) next_state = IDLE;
                    else         do_issue   = 1'b1;
                end
                SEND_TAG: begin
                    tag_valid         = 1'b1;
                    address_tag       = paddr_i[PLEN-1:12];
                    translation_req_o = 1'b1;
                    if (flush_i) begin
                        kill_req   = 1'b1;
                        next_state = IDLE;
                    end else if (ex_i[0]) begin
                        kill_req   = 1'b1;
                        pop_ld_o   = 1'b1;
                        capture_ex = 1'b1;
                        next_state = IDLE;
                    end else if (!dtlb_hit_i) begin
                        kill_req   = 1'b1;
                        next_state = WAIT_TRANSLATION;
                    end else begin
                        pop_ld_o   = 1'b1;
                        latch_ld   = 1'b1;
                        next_state = WAIT_RVALID;
                    end
                end
                WAIT_TRANSLATION: begin
                    translation_req_o = 1'b1;
                    if (flush_i)         next_state = IDLE;
                    else if (dtlb_hit_i) do_issue   = 1'b1;
                end
                WAIT_RVALID: begin
                    if (data_rvalid) begin
                        capture_data = !flush_i;
                        next_state   = IDLE;
                    end else if (flush_i) begin
                        next_state = WAIT_FLUSH;
                    end
                end
                WAIT_FLUSH: begin
                    if (data_rvalid) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
            if (do_issue) begin
                data_req          = 1'b1;
                translation_req_o = 1'b1;
                address_index     = ctrl_vaddr[11:0];
                data_be           = ctrl_be;
                data_size         = ctrl_op[1:0];
                next_state        = data_gnt ? SEND_TAG : WAIT_GNT;
            end
        end
    end

    logic [TRANS_ID_BITS-1:0] id_q;
    logic [2:0]               op_q;
    logic [2:0]               off_q;
    logic [XLEN-1:0]          shifted, extended;

    assign shifted = data_rdata >> {off_q, 3'b000};

    always_comb begin
        extended = shifted;
        case (op_q)
            OP_LB:   extended = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            OP_LH:   extended = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            OP_LW:   extended = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            OP_LBU:  extended = {{(XLEN-8){1'b0}},         shifted[7:0]};
            OP_LHU:  extended = {{(XLEN-16){1'b0}},        shifted[15:0]};
            OP_LWU:  extended = {{(XLEN-32){1'b0}},        shifted[31:0]};
            OP_LD:   extended = shifted;
            default: extended = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
            ex_o       <= '0;
            id_q       <= '0;
            op_q       <= '0;
            off_q      <= '0;
        end else begin
            state   <= next_state;
            valid_o <= 1'b0;
            if (latch_ld) begin
                id_q  <= ctrl_id;
                op_q  <= ctrl_op;
                off_q <= ctrl_vaddr[2:0];
            end
            if (capture_data) begin
                valid_o    <= 1'b1;
                result_o   <= extended;
                trans_id_o <= id_q;
                ex_o       <= '0;
            end else if (capture_ex) begin
                valid_o    <= 1'b1;
                result_o   <= '0;
                trans_id_o <= ctrl_id;
                ex_o       <= ex_i;
            end
        end
    end

endmodule

// File: tb/tb_load_unit_rd.sv
// Directed bench for load_unit_rd: latency, extension, dtlb miss, exception, hazard stall, flush and reset.
module tb_load_unit_rd;
    localparam int XLEN = 64, VLEN = 39, PLEN = 56, TID = 3;
    localparam int CTRL_W = VLEN + 8 + 3 + TID;
    localparam int EX_W = 2 * XLEN + 1;
    localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LD = 3'd3,
                           OP_LBU = 3'd4, OP_LHU = 3'd5, OP_LWU = 3'd6;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_TRANSLATION = 3'd4, S_WAIT_FLUSH = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1, flush = 1'b0, valid = 1'b0;
    logic [CTRL_W-1:0] ctrl = '0;
    logic              pop, valid_o, treq;
    logic [TID-1:0]    trans_id_o;
    logic [XLEN-1:0]   result_o;
    logic [EX_W-1:0]   ex_o;
    logic [VLEN-1:0]   vaddr_o;
    logic [PLEN-1:0]   paddr = '0;
    logic              ex_valid = 1'b0;
    logic [63:0]       ex_cause = '0, ex_tval = '0;
    logic [EX_W-1:0]   ex_in;
    logic              hit = 1'b0;
    logic [11:0]       page_offset;
    logic              pom = 1'b0, sbe = 1'b1;
    logic              gnt = 1'b0, rvalid = 1'b0;
    logic [63:0]       rdata = '0;
    logic [XLEN+1:0]   req_in;
    logic [PLEN+13:0]  req_out;
    logic [2:0]        fsm_state;

    assign ex_in  = {ex_tval, ex_cause, ex_valid};
    assign req_in = {gnt, rvalid, rdata};

    logic             tag_valid, kill_req, data_we, data_req;
    logic [1:0]       rq_size;
    logic [7:0]       rq_be;
    logic [PLEN-13:0] rq_tag;
    logic [11:0]      rq_index;
    assign tag_valid = req_out[0];
    assign kill_req  = req_out[1];
    assign data_we   = req_out[2];
    assign data_req  = req_out[3];
    assign rq_size   = req_out[5:4];
    assign rq_be     = req_out[13:6];
    assign rq_tag    = req_out[PLEN+1:14];
    assign rq_index  = req_out[PLEN+13:PLEN+2];

    load_unit_rd #(.XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_BITS(TID)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .lsu_ctrl_i(ctrl),
        .pop_ld_o(pop), .valid_o(valid_o), .trans_id_o(trans_id_o), .result_o(result_o),
        .ex_o(ex_o), .translation_req_o(treq), .vaddr_o(vaddr_o), .paddr_i(paddr),
        .ex_i(ex_in), .dtlb_hit_i(hit), .page_offset_o(page_offset),
        .page_offset_matches_i(pom), .store_buffer_empty_i(sbe),
        .req_port_i(req_in), .req_port_o(req_out), .fsm_state(fsm_state)
    );

    int checks = 0, errors = 0;
    int pop_cnt = 0, vo_cnt = 0;
    logic [63:0] exp_q[$];
    logic [TID-1:0] cur_id = '0;

    always @(posedge clk) begin
        if (pop)     pop_cnt++;
        if (valid_o) vo_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU: return 2'd0;
            OP_LH, OP_LHU: return 2'd1;
            OP_LW, OP_LWU: return 2'd2;
            default:       return 2'd3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_hazard(input logic on);
`ifdef LOAD_UNIT_PAGE_OFFSET_CHECK_EN
        pom = on;
`else
        sbe = !on;
`endif
    endtask

    task automatic present(input logic [38:0] va, input logic [2:0] op, input logic [2:0] id);
        ctrl   = {va, 8'hFF, op, id};
        valid  = 1'b1;
        gnt    = 1'b1;
        hit    = 1'b1;
        paddr  = {44'hABCDEF01234, va[11:0]};
        cur_id = id;
    endtask

    task automatic issue(input logic [38:0] va, input logic [2:0] op, input logic [2:0] id);
        tick();
        present(va, op, id);
        sample();
        check("issue_req", 64'(data_req), 64'd1);
        check("issue_index", 64'(rq_index), 64'(va[11:0]));
        check("issue_size", 64'(rq_size), 64'(exp_size(op)));
        check("issue_be", 64'(rq_be), 64'hFF);
        check("issue_treq", 64'(treq), 64'd1);
        check("issue_nopop", 64'(pop), 64'd0);
        check("vaddr_o", 64'(vaddr_o), 64'(va));
    endtask

    task automatic tag_phase();
        tick();
        gnt = 1'b0;
        sample();
        check("tag_valid", 64'(tag_valid), 64'd1);
        check("tag_value", 64'(rq_tag), 64'h0ABCDEF01234);
        check("tag_pop", 64'(pop), 64'd1);
        check("tag_nokill", 64'(kill_req), 64'd0);
    endtask

    task automatic data_phase(input logic [63:0] data, input logic [63:0] exp);
        exp_q.push_back(exp);
        tick();
        valid  = 1'b0;
        rvalid = 1'b1;
        rdata  = data;
        sample();
        check("valid_early", 64'(valid_o), 64'd0);
        tick();
        rvalid = 1'b0;
        sample();
        check("valid_o", 64'(valid_o), 64'd1);
        if (exp_q.size() > 0) check("result", result_o, exp_q.pop_front());
        check("trans_id", 64'(trans_id_o), 64'(cur_id));
        check("ex_clear", 64'(ex_o[0]), 64'd0);
        tick();
        sample();
        check("valid_pulse", 64'(valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int p0, v0;
        tick();
        tick();
        sample();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_treq", 64'(treq), 64'd0);
        check("rst_req", 64'(|req_out), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_id", 64'(trans_id_o), 64'd0);
        check("rst_ex", 64'(ex_o[0]), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));
        tick();
        rst = 1'b0;

        // minimum latency LD
        issue(39'h1000, OP_LD, 3'd5);
        tag_phase();
        data_phase(64'h1122334455667788, 64'h1122334455667788);

        // byte / half / word extension
        issue(39'h1003, OP_LB, 3'd1);
        tag_phase();
        data_phase(64'h0000000080000000, 64'hFFFFFFFFFFFFFF80);
        issue(39'h1003, OP_LBU, 3'd2);
        tag_phase();
        data_phase(64'h0000000080000000, 64'h0000000000000080);
        issue(39'h1006, OP_LH, 3'd3);
        tag_phase();
        data_phase(64'h8000000112345678, 64'hFFFFFFFFFFFF8000);
        issue(39'h1006, OP_LHU, 3'd4);
        tag_phase();
        data_phase(64'h8000000112345678, 64'h0000000000008000);
        issue(39'h1004, OP_LW, 3'd5);
        tag_phase();
        data_phase(64'h8000000112345678, 64'hFFFFFFFF80000001);
        issue(39'h1004, OP_LWU, 3'd6);
        tag_phase();
        data_phase(64'h8000000112345678, 64'h0000000080000001);

        // dtlb miss for three cycles, then hit
        p0 = pop_cnt;
        tick();
        present(39'h200C, OP_LW, 3'd2);
        hit = 1'b0;
        sample();
        check("miss_req", 64'(data_req), 64'd1);
        tick();
        gnt = 1'b0;
        sample();
        check("miss_kill", 64'(kill_req), 64'd1);
        check("miss_tagv", 64'(tag_valid), 64'd1);
        check("miss_nopop", 64'(pop), 64'd0);
        tick();
        sample();
        check("miss_noreq", 64'(data_req), 64'd0);
        check("miss_treq", 64'(treq), 64'd1);
        check("miss_state", 64'(fsm_state), 64'(S_WAIT_TRANSLATION));
        tick();
        sample();
        tick();
        hit = 1'b1;
        gnt = 1'b1;
        sample();
        check("miss_reissue", 64'(data_req), 64'd1);
        tag_phase();
        data_phase(64'hDEADBEEF00001111, 64'hFFFFFFFFDEADBEEF);
        check("miss_one_pop", 64'(pop_cnt - p0), 64'd1);

        // page fault in SEND_TAG
        issue(39'h3000, OP_LD, 3'd6);
        v0 = vo_cnt;
        tick();
        gnt      = 1'b0;
        ex_valid = 1'b1;
        ex_cause = 64'd13;
        ex_tval  = 64'h3000;
        sample();
        check("ex_kill", 64'(kill_req), 64'd1);
        check("ex_pop", 64'(pop), 64'd1);
        tick();
        valid    = 1'b0;
        ex_valid = 1'b0;
        sample();
        check("ex_valid_o", 64'(valid_o), 64'd1);
        check("ex_flag", 64'(ex_o[0]), 64'd1);
        check("ex_cause", ex_o[64:1], 64'd13);
        check("ex_result", result_o, 64'd0);
        check("ex_id", 64'(trans_id_o), 64'd6);
        tick();
        tick();
        sample();
        check("ex_one_valid", 64'(vo_cnt - v0), 64'd1);

        // hazard stall for four cycles
        tick();
        present(39'h4010, OP_LD, 3'd1);
        set_hazard(1'b1);
        sample();
        check("haz_noreq0", 64'(data_req), 64'd0);
`ifdef LOAD_UNIT_PAGE_OFFSET_CHECK_EN
        check("page_offset", 64'(page_offset), 64'h010);
`else
        check("page_offset", 64'(page_offset), 64'h000);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("haz_noreq", 64'(data_req), 64'd0);
        end
        tick();
        set_hazard(1'b0);
        sample();
        check("haz_release", 64'(data_req), 64'd1);
        tag_phase();
        data_phase(64'h0123456789ABCDEF, 64'h0123456789ABCDEF);

        // flush with exception in SEND_TAG: flush wins
        issue(39'h6000, OP_LD, 3'd4);
        v0 = vo_cnt;
        p0 = pop_cnt;
        tick();
        gnt      = 1'b0;
        flush    = 1'b1;
        ex_valid = 1'b1;
        sample();
        check("fl_tag_kill", 64'(kill_req), 64'd1);
        check("fl_tag_nopop", 64'(pop), 64'd0);
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        valid    = 1'b0;
        sample();
        check("fl_tag_state", 64'(fsm_state), 64'(S_IDLE));
        tick();
        sample();
        check("fl_tag_novalid", 64'(vo_cnt - v0), 64'd0);
        check("fl_tag_nopops", 64'(pop_cnt - p0), 64'd0);

        // flush in WAIT_RVALID, data two cycles later
        issue(39'h5000, OP_LD, 3'd3);
        tag_phase();
        v0 = vo_cnt;
        tick();
        valid = 1'b0;
        flush = 1'b1;
        sample();
        tick();
        flush = 1'b0;
        sample();
        check("fl_wait_state", 64'(fsm_state), 64'(S_WAIT_FLUSH));
        check("fl_wait_noreq", 64'(data_req), 64'd0);
        tick();
        rvalid = 1'b1;
        rdata  = 64'hFFFF0000FFFF0000;
        sample();
        tick();
        rvalid = 1'b0;
        sample();
        check("fl_idle", 64'(fsm_state), 64'(S_IDLE));
        check("fl_novalid", 64'(valid_o), 64'd0);
        tick();
        sample();
        check("fl_novalid_cnt", 64'(vo_cnt - v0), 64'd0);
        issue(39'h5008, OP_LBU, 3'd7);
        tag_phase();
        data_phase(64'h00000000000000AB, 64'h00000000000000AB);

        // reset mid-transaction, late rvalid ignored
        issue(39'h7000, OP_LD, 3'd1);
        tag_phase();
        tick();
        valid = 1'b0;
        rst   = 1'b1;
        sample();
        tick();
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'h1234;
        sample();
        check("rst_mid_state", 64'(fsm_state), 64'(S_IDLE));
        tick();
        rvalid = 1'b0;
        sample();
        check("rst_mid_novalid", 64'(valid_o), 64'd0);
        check("we_tied", 64'(data_we), 64'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
